// File: rtl/sh7604_intc_pkg.sv
// sh7604_intc_pkg: register layouts, access masks, address offsets and vector constants
// shared by the SH7604 interrupt controller and its arbiter.
package sh7604_intc_pkg;

    typedef struct packed {
        logic [7:0] rsv_hi;
        logic [3:0] wdt;
        logic [3:0] rsv_lo;
    } IPRA_t;

    typedef struct packed {
        logic [3:0] sci;
        logic [3:0] frt;
        logic [7:0] rsv;
    } IPRB_t;

    typedef struct packed {
        logic       rsv_hi;
        logic [6:0] vec_hi;
        logic       rsv_lo;
        logic [6:0] vec_lo;
    } VCR_t;

    typedef struct packed {
        logic [6:0] rsv_hi;
        logic       nmie;
        logic [7:0] rsv_lo;
    } INTC_ICR_t;

    // Array order doubles as the fixed tie-break order (lower index wins).
    typedef enum logic [3:0] {
        SRC_NMI, SRC_IRL, SRC_WDT, SRC_ERI, SRC_RXI,
        SRC_TXI, SRC_TEI, SRC_ICI, SRC_OCI, SRC_OVI
    } intc_src_e;

    localparam int NUM_SRC = 10;
    localparam int LVL_W   = 5;

    localparam logic [27:0] WIN_LO = 28'hFFFFFE6;
    localparam logic [27:0] WIN_HI = 28'hFFFFFEE;

    localparam logic [7:0] ICR_OFS    = 8'hE0;
    localparam logic [7:0] IPRA_OFS   = 8'hE2;
    localparam logic [7:0] VCRWDT_OFS = 8'hE4;
    localparam logic [7:0] IPRB_OFS   = 8'h60;
    localparam logic [7:0] VCRA_OFS   = 8'h62;
    localparam logic [7:0] VCRB_OFS   = 8'h64;
    localparam logic [7:0] VCRC_OFS   = 8'h66;
    localparam logic [7:0] VCRD_OFS   = 8'h68;

    localparam INTC_ICR_t ICR_INIT  = '0;
    localparam IPRA_t     IPRA_INIT = '0;
    localparam IPRB_t     IPRB_INIT = '0;
    localparam VCR_t      VCR_INIT  = '0;

    localparam logic [15:0] ICR_WMASK  = 16'h0100;
    localparam logic [15:0] IPRA_WMASK = 16'h00F0;
    localparam logic [15:0] IPRB_WMASK = 16'hFF00;
    localparam logic [15:0] VCR_WMASK  = 16'h7F7F;
    localparam logic [15:0] VCRH_WMASK = 16'h7F00;

    localparam logic [15:0] ICR_RMASK  = ICR_WMASK;
    localparam logic [15:0] IPRA_RMASK = IPRA_WMASK;
    localparam logic [15:0] IPRB_RMASK = IPRB_WMASK;
    localparam logic [15:0] VCR_RMASK  = VCR_WMASK;
    localparam logic [15:0] VCRH_RMASK = VCRH_WMASK;

    localparam logic [LVL_W-1:0] NMI_LVL      = 5'd16;
    localparam logic [7:0]       NMI_VEC      = 8'd11;
    localparam logic [7:0]       IRL_VEC_BASE = 8'd64;

    function automatic logic [15:0] reg_merge(input logic [15:0] cur, input logic [15:0] din,
                                              input logic [1:0] lanes, input logic [15:0] wmask);
        logic [15:0] m;
        m = {{8{lanes[1]}}, {8{lanes[0]}}} & wmask;
        return (cur & ~m) | (din & m);
    endfunction

endpackage

// File: rtl/sh7604_intc_arb.sv
// sh7604_intc_arb: picks the highest {level, vector} pair out of the ten interrupt sources;
// equal levels resolve to the lowest source index.
module sh7604_intc_arb
    import sh7604_intc_pkg::*;
(
    input  logic [NUM_SRC-1:0][LVL_W-1:0] src_lvl,
    input  logic [NUM_SRC-1:0][7:0]       src_vec,
    output logic                          win_req,
    output logic [LVL_W-1:0]              win_lvl,
    output logic [7:0]                    win_vec,
    output logic [3:0]                    win_src
);

    // Strict greater-than keeps the earlier source on a tie; level 0 never wins.
    always_comb begin
        win_lvl = '0;
        win_vec = '0;
        win_src = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (src_lvl[i] > win_lvl) begin
                win_lvl = src_lvl[i];
                win_vec = src_vec[i];
                win_src = 4'(i);
            end
        end
        win_req = (win_lvl != '0);
    end

endmodule

// File: rtl/sh7604_intc.sv
// sh7604_intc: SH7604 interrupt controller with priority/vector registers, NMI edge flag and
// registered CPU request. Optional IRL pin input enabled by `define SH7604_INTC_IRL_EN.
module sh7604_intc
    import sh7604_intc_pkg::*;
(
    input  logic        CLK,
    input  logic        RST,
    input  logic        CE_R,
    input  logic        CE_F,
    input  logic        NMI,
    input  logic [3:0]  IRL_N,
    input  logic        FRT_ICI,
    input  logic        FRT_OCIA,
    input  logic        FRT_OCIB,
    input  logic        FRT_OVI,
    input  logic        SCI_ERI,
    input  logic        SCI_RXI,
    input  logic        SCI_TXI,
    input  logic        SCI_TEI,
    input  logic        WDT_ITI,
    input  logic [31:0] IBUS_A,
    input  logic [31:0] IBUS_DI,
    output logic [31:0] IBUS_DO,
    input  logic [3:0]  IBUS_BA,
    input  logic        IBUS_WE,
    input  logic        IBUS_REQ,
    output logic        IBUS_BUSY,
    output logic        IBUS_ACT,
    output logic        INT_REQ,
    output logic [3:0]  INT_LVL,
    output logic [7:0]  INT_VEC,
    input  logic        INT_ACK
);

    function automatic logic [3:0] cpu_level(input logic [LVL_W-1:0] lvl);
        return (lvl > 5'd15) ? 4'd15 : lvl[3:0];
    endfunction

    INTC_ICR_t icr;
    IPRA_t     ipra;
    IPRB_t     iprb;
    VCR_t      vcrwdt, vcra, vcrb, vcrc, vcrd;

    logic        sel, hi_half;
    logic [7:0]  ofs;
    logic [1:0]  lanes;
    logic [15:0] wdata, rdata;
    logic [31:0] rd_q;
    logic        unused_bits;

    logic        nmi_prev, nmi_pend, nmi_edge;
    logic [3:0]  irl_lvl;

    logic [NUM_SRC-1:0][LVL_W-1:0] src_lvl;
    logic [NUM_SRC-1:0][7:0]       src_vec;
    logic             arb_req;
    logic [LVL_W-1:0] arb_lvl;
    logic [7:0]       arb_vec;
    logic [3:0]       arb_src;

    logic       req_p2, nmi_sel_p2, ack_ok;
    logic [3:0] lvl_p2;
    logic [7:0] vec_p2;

    // Word registers: A[1]=0 lives on DI/DO[31:16] (lanes BA[3:2]), A[1]=1 on [15:0] (BA[1:0]).
    assign ofs     = {IBUS_A[7:1], 1'b0};
    assign sel     = IBUS_REQ && (IBUS_A[31:4] == WIN_LO || IBUS_A[31:4] == WIN_HI);
    assign hi_half = ~IBUS_A[1];
    assign lanes   = hi_half ? IBUS_BA[3:2] : IBUS_BA[1:0];
    assign wdata   = hi_half ? IBUS_DI[31:16] : IBUS_DI[15:0];

    assign IBUS_ACT  = sel;
    assign IBUS_BUSY = 1'b0;
    assign IBUS_DO   = rd_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            icr    <= ICR_INIT;
            ipra   <= IPRA_INIT;
            iprb   <= IPRB_INIT;
            vcrwdt <= VCR_INIT;
            vcra   <= VCR_INIT;
            vcrb   <= VCR_INIT;
            vcrc   <= VCR_INIT;
            vcrd   <= VCR_INIT;
        end else if (CE_R && sel && IBUS_WE) begin
            case (ofs)
                ICR_OFS:    icr    <= reg_merge(icr,    wdata, lanes, ICR_WMASK);
                IPRA_OFS:   ipra   <= reg_merge(ipra,   wdata, lanes, IPRA_WMASK);
                VCRWDT_OFS: vcrwdt <= reg_merge(vcrwdt, wdata, lanes, VCRH_WMASK);
                IPRB_OFS:   iprb   <= reg_merge(iprb,   wdata, lanes, IPRB_WMASK);
                VCRA_OFS:   vcra   <= reg_merge(vcra,   wdata, lanes, VCR_WMASK);
                VCRB_OFS:   vcrb   <= reg_merge(vcrb,   wdata, lanes, VCR_WMASK);
                VCRC_OFS:   vcrc   <= reg_merge(vcrc,   wdata, lanes, VCR_WMASK);
                VCRD_OFS:   vcrd   <= reg_merge(vcrd,   wdata, lanes, VCRH_WMASK);
                default: ;
            endcase
        end
    end

    always_comb begin
        rdata = '0;
        case (ofs)
            ICR_OFS:    rdata = icr    & ICR_RMASK;
            IPRA_OFS:   rdata = ipra   & IPRA_RMASK;
            VCRWDT_OFS: rdata = vcrwdt & VCRH_RMASK;
            IPRB_OFS:   rdata = iprb   & IPRB_RMASK;
            VCRA_OFS:   rdata = vcra   & VCR_RMASK;
            VCRB_OFS:   rdata = vcrb   & VCR_RMASK;
            VCRC_OFS:   rdata = vcrc   & VCR_RMASK;
            VCRD_OFS:   rdata = vcrd   & VCRH_RMASK;
            default:    rdata = '0;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            rd_q <= '0;
        end else if (CE_F && sel && !IBUS_WE) begin
            rd_q <= hi_half ? {rdata, 16'h0000} : {16'h0000, rdata};
        end
    end

    // A new edge wins over a concurrent NMI ack so the second NMI is not lost.
    assign nmi_edge = icr.nmie ? (NMI && !nmi_prev) : (!NMI && nmi_prev);
    assign ack_ok   = INT_ACK && req_p2;

    always_ff @(posedge CLK) begin
        if (RST) begin
            nmi_prev <= 1'b0;
            nmi_pend <= 1'b0;
        end else if (CE_R) begin
            nmi_prev <= NMI;
            nmi_pend <= nmi_edge || (nmi_pend && !(ack_ok && nmi_sel_p2));
        end
    end

`ifdef SH7604_INTC_IRL_EN
    logic [3:0] irl_p0, irl_p1;

    always_ff @(posedge CLK) begin
        if (RST) begin
            irl_p0 <= '0;
            irl_p1 <= '0;
        end else if (CE_R) begin
            irl_p0 <= ~IRL_N;
            irl_p1 <= irl_p0;
        end
    end

    assign irl_lvl     = irl_p1;
    assign unused_bits = IBUS_A[0];
`else
    assign irl_lvl     = 4'd0;
    assign unused_bits = IBUS_A[0] ^ (^IRL_N);
`endif

    always_comb begin
        src_lvl = '0;
        src_vec = '0;
        src_lvl[SRC_NMI] = nmi_pend ? NMI_LVL : '0;
        src_vec[SRC_NMI] = NMI_VEC;
        src_lvl[SRC_IRL] = {1'b0, irl_lvl};
        src_vec[SRC_IRL] = IRL_VEC_BASE + {5'd0, irl_lvl[3:1]};
        src_lvl[SRC_WDT] = WDT_ITI ? {1'b0, ipra.wdt} : '0;
        src_vec[SRC_WDT] = {1'b0, vcrwdt.vec_hi};
        src_lvl[SRC_ERI] = SCI_ERI ? {1'b0, iprb.sci} : '0;
        src_vec[SRC_ERI] = {1'b0, vcra.vec_hi};
        src_lvl[SRC_RXI] = SCI_RXI ? {1'b0, iprb.sci} : '0;
        src_vec[SRC_RXI] = {1'b0, vcra.vec_lo};
        src_lvl[SRC_TXI] = SCI_TXI ? {1'b0, iprb.sci} : '0;
        src_vec[SRC_TXI] = {1'b0, vcrb.vec_hi};
        src_lvl[SRC_TEI] = SCI_TEI ? {1'b0, iprb.sci} : '0;
        src_vec[SRC_TEI] = {1'b0, vcrb.vec_lo};
        src_lvl[SRC_ICI] = FRT_ICI ? {1'b0, iprb.frt} : '0;
        src_vec[SRC_ICI] = {1'b0, vcrc.vec_hi};
        src_lvl[SRC_OCI] = (FRT_OCIA || FRT_OCIB) ? {1'b0, iprb.frt} : '0;
        src_vec[SRC_OCI] = {1'b0, vcrc.vec_lo};
        src_lvl[SRC_OVI] = FRT_OVI ? {1'b0, iprb.frt} : '0;
        src_vec[SRC_OVI] = {1'b0, vcrd.vec_hi};
    end

    sh7604_intc_arb u_arb (
        .src_lvl (src_lvl),
        .src_vec (src_vec),
        .win_req (arb_req),
        .win_lvl (arb_lvl),
        .win_vec (arb_vec),
        .win_src (arb_src)
    );

    // Output stage: tracks arbitration each CE_R, holds for the cycle an ack is accepted.
    always_ff @(posedge CLK) begin
        if (RST) begin
            req_p2     <= 1'b0;
            lvl_p2     <= '0;
            vec_p2     <= '0;
            nmi_sel_p2 <= 1'b0;
        end else if (CE_R && !ack_ok) begin
            req_p2     <= arb_req;
            lvl_p2     <= cpu_level(arb_lvl);
            vec_p2     <= arb_vec;
            nmi_sel_p2 <= arb_req && (arb_src == SRC_NMI);
        end
    end

    assign INT_REQ = req_p2;
    assign INT_LVL = lvl_p2;
    assign INT_VEC = vec_p2;

endmodule

// File: tb/tb_sh7604_intc.sv
// tb_sh7604_intc: directed and randomized checks of sh7604_intc against a behavioural model.
module tb_sh7604_intc;

`ifdef SH7604_INTC_IRL_EN
    localparam bit IRL_EN = 1'b1;
`else
    localparam bit IRL_EN = 1'b0;
`endif

    localparam logic [31:0] A_ICR    = 32'hFFFFFEE0;
    localparam logic [31:0] A_IPRA   = 32'hFFFFFEE2;
    localparam logic [31:0] A_VCRWDT = 32'hFFFFFEE4;
    localparam logic [31:0] A_IPRB   = 32'hFFFFFE60;
    localparam logic [31:0] A_VCRA   = 32'hFFFFFE62;
    localparam logic [31:0] A_VCRB   = 32'hFFFFFE64;
    localparam logic [31:0] A_VCRC   = 32'hFFFFFE66;
    localparam logic [31:0] A_VCRD   = 32'hFFFFFE68;

    logic        CLK = 1'b0;
    logic        RST, CE_R, CE_F, NMI;
    logic [3:0]  IRL_N;
    logic        FRT_ICI, FRT_OCIA, FRT_OCIB, FRT_OVI;
    logic        SCI_ERI, SCI_RXI, SCI_TXI, SCI_TEI, WDT_ITI;
    logic [31:0] IBUS_A, IBUS_DI;
    logic [31:0] IBUS_DO;
    logic [3:0]  IBUS_BA;
    logic        IBUS_WE, IBUS_REQ;
    logic        IBUS_BUSY, IBUS_ACT;
    logic        INT_REQ;
    logic [3:0]  INT_LVL;
    logic [7:0]  INT_VEC;
    logic        INT_ACK;

    int vectors = 0;
    int errors  = 0;

    // Behavioural model state
    logic [15:0] mr    [logic [31:0]];
    logic [15:0] mmask [logic [31:0]];
    bit          m_pend, m_prev, m_req, m_nmi_sel;
    logic [3:0]  m_lvl, m_irl1, m_irl2;
    logic [7:0]  m_vec;
    logic [31:0] m_do;

    sh7604_intc dut (
        .CLK(CLK), .RST(RST), .CE_R(CE_R), .CE_F(CE_F), .NMI(NMI), .IRL_N(IRL_N),
        .FRT_ICI(FRT_ICI), .FRT_OCIA(FRT_OCIA), .FRT_OCIB(FRT_OCIB), .FRT_OVI(FRT_OVI),
        .SCI_ERI(SCI_ERI), .SCI_RXI(SCI_RXI), .SCI_TXI(SCI_TXI), .SCI_TEI(SCI_TEI),
        .WDT_ITI(WDT_ITI), .IBUS_A(IBUS_A), .IBUS_DI(IBUS_DI), .IBUS_DO(IBUS_DO),
        .IBUS_BA(IBUS_BA), .IBUS_WE(IBUS_WE), .IBUS_REQ(IBUS_REQ), .IBUS_BUSY(IBUS_BUSY),
        .IBUS_ACT(IBUS_ACT), .INT_REQ(INT_REQ), .INT_LVL(INT_LVL), .INT_VEC(INT_VEC),
        .INT_ACK(INT_ACK)
    );

    always #5 CLK = ~CLK;

    function automatic bit in_win(input logic [31:0] a);
        return (a >= 32'hFFFFFE60 && a <= 32'hFFFFFE6F) || (a >= 32'hFFFFFEE0 && a <= 32'hFFFFFEEF);
    endfunction

    task automatic model_reset();
        mr[A_ICR] = 0; mr[A_IPRA] = 0; mr[A_VCRWDT] = 0; mr[A_IPRB] = 0;
        mr[A_VCRA] = 0; mr[A_VCRB] = 0; mr[A_VCRC] = 0; mr[A_VCRD] = 0;
        mmask[A_ICR] = 16'h0100; mmask[A_IPRA] = 16'h00F0; mmask[A_VCRWDT] = 16'h7F00;
        mmask[A_IPRB] = 16'hFF00; mmask[A_VCRA] = 16'h7F7F; mmask[A_VCRB] = 16'h7F7F;
        mmask[A_VCRC] = 16'h7F7F; mmask[A_VCRD] = 16'h7F00;
        m_pend = 0; m_prev = 0; m_req = 0; m_nmi_sel = 0;
        m_lvl = 0; m_vec = 0; m_irl1 = 0; m_irl2 = 0; m_do = 0;
    endtask

    // Highest level wins; sources listed in tie-break order NMI, IRL, WDT, ERI..OVI.
    function automatic void m_arb(output bit r, output int l, output int v, output bit n);
        int L[10];
        int V[10];
        int best, bi, ipra, iprb, vw, va, vb, vc, vd, sci, frt;
        ipra = int'(mr[A_IPRA]); iprb = int'(mr[A_IPRB]); vw = int'(mr[A_VCRWDT]);
        va = int'(mr[A_VCRA]); vb = int'(mr[A_VCRB]); vc = int'(mr[A_VCRC]); vd = int'(mr[A_VCRD]);
        sci = (iprb >> 12) & 15;
        frt = (iprb >> 8) & 15;
        L[0] = m_pend ? 16 : 0;                    V[0] = 11;
        L[1] = IRL_EN ? int'(m_irl2) : 0;          V[1] = 64 + int'(m_irl2) / 2;
        L[2] = WDT_ITI ? (ipra >> 4) & 15 : 0;     V[2] = (vw >> 8) & 127;
        L[3] = SCI_ERI ? sci : 0;                  V[3] = (va >> 8) & 127;
        L[4] = SCI_RXI ? sci : 0;                  V[4] = va & 127;
        L[5] = SCI_TXI ? sci : 0;                  V[5] = (vb >> 8) & 127;
        L[6] = SCI_TEI ? sci : 0;                  V[6] = vb & 127;
        L[7] = FRT_ICI ? frt : 0;                  V[7] = (vc >> 8) & 127;
        L[8] = (FRT_OCIA || FRT_OCIB) ? frt : 0;   V[8] = vc & 127;
        L[9] = FRT_OVI ? frt : 0;                  V[9] = (vd >> 8) & 127;
        best = 0;
        bi = 0;
        for (int i = 0; i < 10; i++) begin
            if (L[i] > best) begin
                best = L[i];
                bi = i;
            end
        end
        r = (best > 0);
        l = (best > 15) ? 15 : best;
        v = r ? V[bi] : 0;
        n = r && (bi == 0);
    endfunction

    // One CE_R clock followed by one CE_F clock, with the model advanced alongside.
    task automatic step();
        bit nmie, edge_n, ack_v, a_req, a_nmi;
        int a_lvl, a_vec;
        logic [15:0] cur, d, m;
        logic [1:0]  be;
        logic [31:0] key;
        cur = mr[A_ICR];
        nmie = cur[8];
        edge_n = nmie ? (NMI && !m_prev) : (!NMI && m_prev);
        ack_v = INT_ACK && m_req;
        m_arb(a_req, a_lvl, a_vec, a_nmi);
        CE_R = 1'b1; CE_F = 1'b0;
        @(posedge CLK); #1;
        if (!ack_v) begin
            m_req = a_req; m_lvl = 4'(a_lvl); m_vec = 8'(a_vec); m_nmi_sel = a_nmi;
        end
        m_pend = edge_n ? 1'b1 : ((ack_v && m_nmi_sel) ? 1'b0 : m_pend);
        m_prev = NMI;
        m_irl2 = m_irl1;
        m_irl1 = ~IRL_N;
        key = {IBUS_A[31:1], 1'b0};
        if (IBUS_REQ && IBUS_WE && mr.exists(key)) begin
            be = IBUS_A[1] ? IBUS_BA[1:0] : IBUS_BA[3:2];
            d  = IBUS_A[1] ? IBUS_DI[15:0] : IBUS_DI[31:16];
            m  = {{8{be[1]}}, {8{be[0]}}} & mmask[key];
            mr[key] = (mr[key] & ~m) | (d & m);
        end
        CE_R = 1'b0; CE_F = 1'b1;
        @(posedge CLK); #1;
        if (IBUS_REQ && !IBUS_WE && in_win(IBUS_A)) begin
            d = mr.exists(key) ? mr[key] : 16'h0;
            m_do = IBUS_A[1] ? {16'h0, d} : {d, 16'h0};
        end
        CE_F = 1'b0;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [15:0] d);
        IBUS_A = a;
        IBUS_DI = a[1] ? {16'h0, d} : {d, 16'h0};
        IBUS_BA = a[1] ? 4'b0011 : 4'b1100;
        IBUS_WE = 1'b1; IBUS_REQ = 1'b1;
        step();
        IBUS_REQ = 1'b0; IBUS_WE = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a);
        IBUS_A = a; IBUS_WE = 1'b0; IBUS_REQ = 1'b1;
        step();
        IBUS_REQ = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b1; CE_R = 0; CE_F = 0; NMI = 0; IRL_N = 4'hF; INT_ACK = 0;
        {FRT_ICI, FRT_OCIA, FRT_OCIB, FRT_OVI} = '0;
        {SCI_ERI, SCI_RXI, SCI_TXI, SCI_TEI, WDT_ITI} = '0;
        IBUS_A = 0; IBUS_DI = 0; IBUS_BA = 0; IBUS_WE = 0; IBUS_REQ = 0;
        repeat (3) @(posedge CLK);
        #1; RST = 1'b0;
        model_reset();
        vectors++;
        if ({INT_REQ, INT_LVL, INT_VEC} !== 13'h0) begin
            errors++; $display("FAIL reset_int: got req=%0b lvl=%0d vec=%h, need all 0", INT_REQ, INT_LVL, INT_VEC);
        end
        vectors++;
        if ({IBUS_DO, IBUS_BUSY, IBUS_ACT} !== 34'h0) begin
            errors++; $display("FAIL reset_bus: got do=%h busy=%0b act=%0b, need 0", IBUS_DO, IBUS_BUSY, IBUS_ACT);
        end
    endtask

    task automatic test_frt_oci();
        bus_write(A_IPRB, 16'h0500);
        bus_write(A_VCRC, 16'h4142);
        FRT_OCIB = 1'b1;
        step();
        vectors++;
        if ({INT_REQ, INT_LVL, INT_VEC} !== {1'b1, 4'd5, 8'h42}) begin
            errors++; $display("FAIL oci_assert: got req=%0b lvl=%0d vec=%h, need 1/5/42", INT_REQ, INT_LVL, INT_VEC);
        end
        FRT_OCIB = 1'b0;
        step();
        vectors++;
        if (INT_REQ !== 1'b0) begin
            errors++; $display("FAIL oci_deassert: got req=%0b, need 0", INT_REQ);
        end
    endtask

    task automatic test_tie();
        bus_write(A_VCRA, 16'h0030);
        bus_write(A_IPRB, 16'h5500);
        FRT_ICI = 1'b1; SCI_RXI = 1'b1;
        step();
        vectors++;
        if ({INT_REQ, INT_LVL, INT_VEC} !== {1'b1, 4'd5, 8'h30}) begin
            errors++; $display("FAIL tie_rxi: got req=%0b lvl=%0d vec=%h, need 1/5/30", INT_REQ, INT_LVL, INT_VEC);
        end
        bus_write(A_IPRB, 16'h0600);
        step();
        vectors++;
        if ({INT_REQ, INT_LVL, INT_VEC} !== {1'b1, 4'd6, 8'h41}) begin
            errors++; $display("FAIL tie_reprio: got req=%0b lvl=%0d vec=%h, need 1/6/41", INT_REQ, INT_LVL, INT_VEC);
        end
        FRT_ICI = 1'b0; SCI_RXI = 1'b0;
        step();
    endtask

    task automatic test_nmi();
        bus_write(A_ICR, 16'h0000);
        bus_write(A_IPRB, 16'h0500);
        FRT_ICI = 1'b1;
        NMI = 1'b1; step();
        NMI = 1'b0; step();
        step();
        vectors++;
        if ({INT_REQ, INT_LVL, INT_VEC} !== {1'b1, 4'd15, 8'd11}) begin
            errors++; $display("FAIL nmi_fall: got req=%0b lvl=%0d vec=%0d, need 1/15/11", INT_REQ, INT_LVL, INT_VEC);
        end
        INT_ACK = 1'b1; step(); INT_ACK = 1'b0;
        vectors++;
        if (INT_VEC !== 8'd11) begin
            errors++; $display("FAIL nmi_ack_hold: got vec=%0d, need 11", INT_VEC);
        end
        step();
        vectors++;
        if ({INT_REQ, INT_LVL, INT_VEC} !== {1'b1, 4'd5, 8'h41}) begin
            errors++; $display("FAIL nmi_after_ack: got req=%0b lvl=%0d vec=%h, need 1/5/41", INT_REQ, INT_LVL, INT_VEC);
        end
        // Rising-edge mode: a second edge coincident with the ack must stay pending.
        bus_write(A_ICR, 16'h0100);
        NMI = 1'b1; step();
        step();
        NMI = 1'b0; step();
        INT_ACK = 1'b1; NMI = 1'b1; step(); INT_ACK = 1'b0;
        step();
        vectors++;
        if ({INT_REQ, INT_LVL, INT_VEC} !== {1'b1, 4'd15, 8'd11}) begin
            errors++; $display("FAIL nmi_coincident: got req=%0b lvl=%0d vec=%0d, need 1/15/11", INT_REQ, INT_LVL, INT_VEC);
        end
        INT_ACK = 1'b1; step(); INT_ACK = 1'b0;
        step();
        vectors++;
        if ({INT_REQ, INT_LVL, INT_VEC} !== {1'b1, 4'd5, 8'h41}) begin
            errors++; $display("FAIL nmi_second_ack: got req=%0b lvl=%0d vec=%h, need 1/5/41", INT_REQ, INT_LVL, INT_VEC);
        end
        FRT_ICI = 1'b0; NMI = 1'b0;
        bus_write(A_ICR, 16'h0000);
        step();
    endtask

    task automatic test_irl();
        IRL_N = 4'b0010;
        step(); step();
        vectors++;
        if (INT_REQ !== 1'b0) begin
            errors++; $display("FAIL irl_early: got req=%0b after 2 CE_R, need 0", INT_REQ);
        end
        step();
        vectors++;
        if (IRL_EN) begin
            if ({INT_REQ, INT_LVL, INT_VEC} !== {1'b1, 4'd13, 8'd70}) begin
                errors++; $display("FAIL irl_level: got req=%0b lvl=%0d vec=%0d, need 1/13/70", INT_REQ, INT_LVL, INT_VEC);
            end
        end else begin
            if (INT_REQ !== 1'b0) begin
                errors++; $display("FAIL irl_disabled: got req=%0b, need 0", INT_REQ);
            end
        end
        IRL_N = 4'hF;
        repeat (3) step();
    endtask

    task automatic test_bus();
        bus_write(A_VCRWDT, 16'h7F00);
        bus_write(A_IPRA, 16'h00F0);
        WDT_ITI = 1'b1;
        bus_read(A_VCRWDT);
        vectors++;
        if (IBUS_DO[31:16] !== 16'h7F00 || IBUS_DO !== m_do) begin
            errors++; $display("FAIL vcrwdt_read: got %h, need %h", IBUS_DO, 32'h7F000000);
        end
        vectors++;
        if ({INT_REQ, INT_LVL, INT_VEC} !== {1'b1, 4'd15, 8'h7F}) begin
            errors++; $display("FAIL wdt_req: got req=%0b lvl=%0d vec=%h, need 1/15/7f", INT_REQ, INT_LVL, INT_VEC);
        end
        bus_read(A_IPRA);
        vectors++;
        if (IBUS_DO !== 32'h000000F0) begin
            errors++; $display("FAIL ipra_read: got %h, need 000000f0", IBUS_DO);
        end
        IBUS_REQ = 1'b1; IBUS_A = A_IPRB; #1;
        vectors++;
        if (IBUS_ACT !== 1'b1 || IBUS_BUSY !== 1'b0) begin
            errors++; $display("FAIL act_in: got act=%0b busy=%0b, need 1/0", IBUS_ACT, IBUS_BUSY);
        end
        IBUS_A = 32'hFFFFFE70; #1;
        vectors++;
        if (IBUS_ACT !== 1'b0) begin
            errors++; $display("FAIL act_out: got act=%0b, need 0", IBUS_ACT);
        end
        IBUS_REQ = 1'b0;
        IBUS_A = A_IPRB; IBUS_DI = 32'hABCD0000; IBUS_WE = 1'b1; IBUS_REQ = 1'b1;
        IBUS_BA = 4'b0100; step();
        IBUS_BA = 4'b1000; step();
        IBUS_WE = 1'b0; IBUS_REQ = 1'b0;
        bus_read(A_IPRB);
        vectors++;
        if (IBUS_DO !== 32'hAB000000 || IBUS_DO !== m_do) begin
            errors++; $display("FAIL byte_lane: got %h, need ab000000", IBUS_DO);
        end
        bus_write(A_VCRA, 16'hFFFF);
        bus_read(A_VCRA);
        vectors++;
        if (IBUS_DO !== 32'h00007F7F) begin
            errors++; $display("FAIL unused_bits: got %h, need 00007f7f", IBUS_DO);
        end
        bus_write(A_IPRB, 16'h0000);
    endtask

    task automatic test_reset_mid();
        step();
        vectors++;
        if (INT_REQ !== 1'b1) begin
            errors++; $display("FAIL mid_pre: got req=%0b, need 1", INT_REQ);
        end
        RST = 1'b1;
        @(posedge CLK); #1;
        vectors++;
        if ({INT_REQ, INT_LVL, INT_VEC, IBUS_DO} !== 45'h0) begin
            errors++; $display("FAIL mid_reset: got req=%0b lvl=%0d vec=%h do=%h, need all 0", INT_REQ, INT_LVL, INT_VEC, IBUS_DO);
        end
        RST = 1'b0;
        model_reset();
        bus_read(A_IPRA);
        vectors++;
        if (IBUS_DO !== 32'h0 || INT_REQ !== 1'b0) begin
            errors++; $display("FAIL mid_readback: got do=%h req=%0b, need 0/0", IBUS_DO, INT_REQ);
        end
        WDT_ITI = 1'b0;
    endtask

    task automatic test_random();
        logic [31:0] addrs [8];
        addrs = '{A_ICR, A_IPRA, A_VCRWDT, A_IPRB, A_VCRA, A_VCRB, A_VCRC, A_VCRD};
        for (int n = 0; n < 400; n++) begin
            {FRT_ICI, FRT_OCIA, FRT_OCIB, FRT_OVI} = 4'($urandom);
            {SCI_ERI, SCI_RXI, SCI_TXI, SCI_TEI} = 4'($urandom);
            WDT_ITI = 1'($urandom);
            if ($urandom_range(0, 3) == 0) NMI = ~NMI;
            if ($urandom_range(0, 7) == 0) IRL_N = 4'($urandom);
            INT_ACK = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 5) == 0) bus_write(addrs[$urandom_range(0, 7)], 16'($urandom));
            else step();
            INT_ACK = 1'b0;
            vectors++;
            if ({INT_REQ, INT_LVL, INT_VEC} !== {m_req, m_lvl, m_vec}) begin
                errors++;
                $display("FAIL random_%0d: got req=%0b lvl=%0d vec=%h, need req=%0b lvl=%0d vec=%h",
                         n, INT_REQ, INT_LVL, INT_VEC, m_req, m_lvl, m_vec);
            end
        end
    endtask

    initial begin
        test_reset();
        test_frt_oci();
        test_tie();
        test_nmi();
        test_irl();
        test_bus();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
